alu_exec_ctrl: RTL and testbench

Operand-fetch and writeback stage wrapped around the 8-bit combinational ALU (3-bit select; flags carry, zero, neg, over). It accepts one operation request over a valid/ready handshake and reads operands from a local register file. It drives the ALU inputs from registers, then captures the result and flags and writes the result back. One operation is in flight at a time, with a fixed 4-cycle occupancy.

---
 rtl/alu_exec_ctrl.sv | 119 +++++++++++
 tb/tb_alu_exec_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// Operand-fetch / writeback wrapper around an external combinational ALU.
// One request in flight at a time: IDLE -> READ -> EXEC -> WB, 4-cycle occupancy.
module alu_exec_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_rd,
  input  logic [AW-1:0] req_rs,
  input  logic [AW-1:0] req_rt,
  input  logic          req_imm_en,
  input  logic [DW-1:0] req_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_carry,
  input  logic          alu_zero,
  input  logic          alu_neg,
  input  logic          alu_over,
  output logic          done,
  output logic [DW-1:0] result,
  output logic [3:0]    flags,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  state_e        state_q;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
  logic          imm_en_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [2:0]    alu_sel_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] result_q;
  logic [3:0]    flags_q, flags_d;
  logic          done_q;
  logic [DW-1:0] rf_q [NREGS];

  // Flags are {C,Z,N,V}; C only follows ADD, V follows ADD/SUB, Z/N always.
  always_comb begin
    flags_d    = flags_q;
    flags_d[2] = alu_zero;
    flags_d[1] = alu_neg;
    if (alu_sel_q == 3'b000) flags_d[3] = alu_carry;
    if (alu_sel_q == 3'b000 || alu_sel_q == 3'b001) flags_d[0] = alu_over;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_en_q  <= 1'b0;
      imm_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      rf_q      <= '{default: '0};
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            rd_q     <= req_rd;
            rs_q     <= req_rs;
            rt_q     <= req_rt;
            imm_en_q <= req_imm_en;
            imm_q    <= req_imm;
            state_q  <= READ;
          end
        end
        READ: begin
          alu_a_q   <= rf_q[rs_q];
          alu_b_q   <= imm_en_q ? imm_q : rf_q[rt_q];
          alu_sel_q <= op_q;
          state_q   <= EXEC;
        end
        EXEC: begin
          res_q   <= alu_out;
          flags_q <= flags_d;
          done_q  <= 1'b1;
          state_q <= WB;
        end
        WB: begin
          rf_q[rd_q] <= res_q;
          result_q   <= res_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign done      = done_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural 8-bit ALU hooked to its ALU ports.
module tb_alu_exec_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [1:0] req_rd, req_rs, req_rt;
  logic       req_imm_en;
  logic [7:0] req_imm;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry, alu_zero, alu_neg, alu_over;
  logic       done;
  logic [7:0] result;
  logic [3:0] flags;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  alu_exec_ctrl #(.DW(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
    .req_imm_en(req_imm_en), .req_imm(req_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_over(alu_over),
    .done(done), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry/over are driven high on non-arithmetic ops so flag masking is observable.
  logic [8:0] sum;
  always_comb begin
    sum       = '0;
    alu_out   = '0;
    alu_carry = 1'b1;
    alu_over  = 1'b1;
    case (alu_sel)
      3'b000: begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out   = sum[7:0];
        alu_carry = sum[8];
        alu_over  = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      3'b001: begin
        alu_out   = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
        alu_over  = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = alu_a;
      3'b101: alu_out = alu_a << 1;
      3'b110: alu_out = alu_a >> 1;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == 8'h00);
    alu_neg  = alu_out[7];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic set_req(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic imm_en, input logic [7:0] imm);
    req_op = op; req_rd = rd; req_rs = rs; req_rt = rt;
    req_imm_en = imm_en; req_imm = imm;
  endtask

  // Issues one request from IDLE and checks every cycle up to the return to IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs, input logic [1:0] rt, input logic imm_en,
                        input logic [7:0] imm, input logic [7:0] exp_a, input logic [7:0] exp_b,
                        input logic [7:0] exp_res, input logic [3:0] exp_flags);
    check({tag, ".ready0"}, {31'h0, req_ready}, 32'd1);
    set_req(op, rd, rs, rt, imm_en, imm);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check({tag, ".ready1"}, {31'h0, req_ready}, 32'd0);
    check({tag, ".done1"},  {31'h0, done},      32'd0);
    tick();
    check({tag, ".ready2"}, {31'h0, req_ready}, 32'd0);
    check({tag, ".alu_a"},   {24'h0, alu_a},   {24'h0, exp_a});
    check({tag, ".alu_b"},   {24'h0, alu_b},   {24'h0, exp_b});
    check({tag, ".alu_sel"}, {29'h0, alu_sel}, {29'h0, op});
    tick();
    check({tag, ".ready3"}, {31'h0, req_ready}, 32'd0);
    check({tag, ".done3"},  {31'h0, done},      32'd1);
    check({tag, ".flags"},  {28'h0, flags},     {28'h0, exp_flags});
    tick();
    check({tag, ".done4"},  {31'h0, done},      32'd0);
    check({tag, ".ready4"}, {31'h0, req_ready}, 32'd1);
    check({tag, ".result"}, {24'h0, result},    {24'h0, exp_res});
    check_rf({tag, ".rf"}, rd, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rdy_seen, done_seen;
    int          done_cnt;

    rst_n = 1'b0; req_valid = 1'b0; dbg_addr = '0;
    set_req(3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    #1;

    check("rst.ready", {31'h0, req_ready}, 32'd1);
    check("rst.done",  {31'h0, done},      32'd0);
    check("rst.alu_a", {24'h0, alu_a},     32'h0);
    check("rst.alu_b", {24'h0, alu_b},     32'h0);
    check("rst.sel",   {29'h0, alu_sel},   32'h0);
    check("rst.result",{24'h0, result},    32'h0);
    check("rst.flags", {28'h0, flags},     32'h0);
    for (int i = 0; i < 4; i++) check_rf("rst.rf", 2'(i), 8'h00);

    run_op("add7f",  3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h00, 8'h7F, 8'h7F, 4'b0000);
    run_op("add80",  3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'h7F, 8'h01, 8'h80, 4'b0011);
    run_op("addwrap",3'b000, 2'd3, 2'd2, 2'd0, 1'b1, 8'h80, 8'h80, 8'h80, 8'h00, 4'b1101);
    run_op("sub",    3'b001, 2'd0, 2'd1, 2'd1, 1'b0, 8'hAA, 8'h7F, 8'h7F, 8'h00, 4'b1100);
    run_op("and",    3'b010, 2'd1, 2'd1, 2'd0, 1'b1, 8'h0F, 8'h7F, 8'h0F, 8'h0F, 4'b1000);

    // Backpressure: OR held valid while an ADD is in flight.
    rdy_seen = '0; done_seen = '0;
    set_req(3'b000, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01);
    req_valid = 1'b1;
    tick();
    set_req(3'b011, 2'd2, 2'd1, 2'd0, 1'b1, 8'h30);
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) req_valid = 1'b0;
      rdy_seen[c]  = req_ready;
      done_seen[c] = done;
      if (c == 2) check("bp.add_b", {24'h0, alu_b}, 32'h01);
      if (c == 6) begin
        check("bp.or_b",   {24'h0, alu_b},   32'h30);
        check("bp.or_sel", {29'h0, alu_sel}, 32'h3);
      end
      tick();
    end
    check("bp.ready_trace", {21'h0, rdy_seen},  32'h710);
    check("bp.done_trace",  {21'h0, done_seen}, 32'h088);
    check_rf("bp.r3", 2'd3, 8'h10);
    check_rf("bp.r2", 2'd2, 8'h3F);
    check("bp.result", {24'h0, result}, 32'h3F);
    check("bp.flags",  {28'h0, flags},  32'h0);

    run_op("zero", 3'b111, 2'd2, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0100);

    // Reset while in EXEC discards the operation.
    set_req(3'b000, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("mid.alu_a_pre", {24'h0, alu_a}, 32'h0F);
    rst_n = 1'b0;
    #1;
    check("mid.alu_a",  {24'h0, alu_a},   32'h0);
    check("mid.alu_b",  {24'h0, alu_b},   32'h0);
    check("mid.result", {24'h0, result},  32'h0);
    check("mid.flags",  {28'h0, flags},   32'h0);
    check("mid.done",   {31'h0, done},    32'd0);
    for (int i = 0; i < 4; i++) check_rf("mid.rf", 2'(i), 8'h00);
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_cnt++;
      tick();
    end
    check("mid.no_done", done_cnt, 0);
    check_rf("mid.r1", 2'd1, 8'h00);
    check("mid.ready", {31'h0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
